// File: rtl/mcu_spi_pkg.sv
// Shared constants for the MCU SPI slave: header default, packet geometry,
// byte offsets of each packet field and the handshake FSM state encoding.
package mcu_spi_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hAA;
  localparam int unsigned PKT_BYTES      = 32;
  localparam int unsigned PKT_BITS       = PKT_BYTES * 8;
  localparam int unsigned PTR_W          = 8;

  // Byte index of the first byte of each field (byte 0 is sent first)
  localparam int unsigned OFS_HEADER = 0;
  localparam int unsigned OFS_QUAT1  = 1;
  localparam int unsigned OFS_GYRO1  = 9;
  localparam int unsigned OFS_FLAGS1 = 15;
  localparam int unsigned OFS_QUAT2  = 16;
  localparam int unsigned OFS_GYRO2  = 24;
  localparam int unsigned OFS_FLAGS2 = 30;
  localparam int unsigned OFS_CSUM   = 31;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    READY   = 2'd1,
    ACK     = 2'd2
  } state_t;

endpackage

// File: rtl/mcu_spi_if.sv
// MCU-facing SPI link plus packet handshake.
//   sck  : serial clock from MCU (Mode 0)     sdi  : MCU data, ignored
//   sdo  : serial data to MCU, MSB first      load : MCU consumed the packet
//   done : packet ready for reading
interface mcu_spi_if;
  logic sck;
  logic sdi;
  logic sdo;
  logic load;
  logic done;

  modport slave  (input sck, sdi, load, output sdo, done);
  modport master (output sck, sdi, load, input sdo, done);
endinterface

// File: rtl/spi_tx_shifter.sv
// sck-domain bit pointer and sdo mux over the frozen packet register.
//   sck    : SPI clock, pointer advances on its falling edge
//   clr_n  : async clear of the pointer (low while not READY or in reset)
//   packet : frozen packet, bit PKT_BITS-1 is sent first
//   sdo    : packet bit (PKT_BITS-1 - pointer), combinational
module spi_tx_shifter
  import mcu_spi_pkg::*;
(
  input  logic                sck,
  input  logic                clr_n,
  input  logic [PKT_BITS-1:0] packet,
  output logic                sdo
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PKT_BITS - 1);

  logic [PTR_W-1:0] ptr_q;

  // Advance on falling sck so sdo is stable at the master's rising-edge sample
  always_ff @(negedge sck or negedge clr_n) begin
    if (!clr_n) begin
      ptr_q <= '0;
    end else if (ptr_q != PTR_LAST) begin
      ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  assign sdo = packet[PTR_LAST - ptr_q];

endmodule

// File: rtl/mcu_spi_slave.sv
// Sensor packet builder and SPI slave for an MCU master.
// Captures two quaternion/gyro sensor sets into a 32-byte packet (header,
// big-endian fields, valid flags, XOR checksum), holds it frozen while done
// is high and hands it out bit-serially on sdo; the MCU acknowledges via load.
//   clk, rst_n : system clock, async active-low reset
//   spi        : sck/sdi/load in, sdo/done out
//   quatN_*, gyroN_*, *_valid : sensor samples and their valid flags
module mcu_spi_slave #(
  parameter logic [7:0]  HEADER    = mcu_spi_pkg::HEADER_DEFAULT,
  parameter int unsigned PKT_BYTES = mcu_spi_pkg::PKT_BYTES
) (
  input  logic               clk,
  input  logic               rst_n,
  mcu_spi_if.slave           spi,
  input  logic               quat1_valid,
  input  logic               gyro1_valid,
  input  logic               quat2_valid,
  input  logic               gyro2_valid,
  input  logic signed [15:0] quat1_w,
  input  logic signed [15:0] quat1_x,
  input  logic signed [15:0] quat1_y,
  input  logic signed [15:0] quat1_z,
  input  logic signed [15:0] quat2_w,
  input  logic signed [15:0] quat2_x,
  input  logic signed [15:0] quat2_y,
  input  logic signed [15:0] quat2_z,
  input  logic signed [15:0] gyro1_x,
  input  logic signed [15:0] gyro1_y,
  input  logic signed [15:0] gyro1_z,
  input  logic signed [15:0] gyro2_x,
  input  logic signed [15:0] gyro2_y,
  input  logic signed [15:0] gyro2_z
);

  import mcu_spi_pkg::*;

  localparam int unsigned PKT_W  = PKT_BYTES * 8;
  localparam int unsigned BODY_W = PKT_W - 8;

  // Top bit of byte `ofs` inside the header..flags2 body
  function automatic int unsigned body_hi(int unsigned ofs);
    return BODY_W - 1 - 8 * ofs;
  endfunction

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic               capture_c;
  logic               load_meta_q, load_sync_q;
  logic [PKT_W-1:0]   packet_q;
  logic [BODY_W-1:0]  body_c;
  logic [7:0]         csum_c;
  logic               ptr_clr_n_c;
  logic               unused_sdi;

  assign unused_sdi = spi.sdi;

  // Packet body: header, fields MSB byte first, flags = {6'b0, gyro, quat}
  always_comb begin
    body_c = '0;
    body_c[body_hi(OFS_HEADER)    -: 8]  = HEADER;
    body_c[body_hi(OFS_QUAT1)     -: 16] = quat1_w;
    body_c[body_hi(OFS_QUAT1 + 2) -: 16] = quat1_x;
    body_c[body_hi(OFS_QUAT1 + 4) -: 16] = quat1_y;
    body_c[body_hi(OFS_QUAT1 + 6) -: 16] = quat1_z;
    body_c[body_hi(OFS_GYRO1)     -: 16] = gyro1_x;
    body_c[body_hi(OFS_GYRO1 + 2) -: 16] = gyro1_y;
    body_c[body_hi(OFS_GYRO1 + 4) -: 16] = gyro1_z;
    body_c[body_hi(OFS_FLAGS1)    -: 8]  = {6'b0, gyro1_valid, quat1_valid};
    body_c[body_hi(OFS_QUAT2)     -: 16] = quat2_w;
    body_c[body_hi(OFS_QUAT2 + 2) -: 16] = quat2_x;
    body_c[body_hi(OFS_QUAT2 + 4) -: 16] = quat2_y;
    body_c[body_hi(OFS_QUAT2 + 6) -: 16] = quat2_z;
    body_c[body_hi(OFS_GYRO2)     -: 16] = gyro2_x;
    body_c[body_hi(OFS_GYRO2 + 2) -: 16] = gyro2_y;
    body_c[body_hi(OFS_GYRO2 + 4) -: 16] = gyro2_z;
    body_c[body_hi(OFS_FLAGS2)    -: 8]  = {6'b0, gyro2_valid, quat2_valid};
  end

  // Trailing checksum: XOR of every body byte
  always_comb begin
    csum_c = '0;
    for (int unsigned i = OFS_HEADER; i < OFS_CSUM; i++) begin
      csum_c = csum_c ^ body_c[body_hi(i) -: 8];
    end
  end

  // load synchronizer, FSM state, done and packet registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_meta_q <= 1'b0;
      load_sync_q <= 1'b0;
      state_q     <= CAPTURE;
      done_q      <= 1'b0;
      packet_q    <= '0;
    end else begin
      load_meta_q <= spi.load;
      load_sync_q <= load_meta_q;
      state_q     <= state_d;
      done_q      <= done_d;
      if (capture_c) begin
        packet_q <= {body_c, csum_c};
      end
    end
  end

  // Handshake: capture once, hold until load rises, wait for load to fall
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    capture_c = 1'b0;
    case (state_q)
      CAPTURE: begin
        capture_c = 1'b1;
        state_d   = READY;
        done_d    = 1'b1;
      end
      READY: begin
        done_d = 1'b1;
        if (load_sync_q) begin
          state_d = ACK;
          done_d  = 1'b0;
        end
      end
      ACK: begin
        done_d = 1'b0;
        if (!load_sync_q) begin
          state_d = CAPTURE;
        end
      end
      default: begin
        state_d = CAPTURE;
        done_d  = 1'b0;
      end
    endcase
  end

  assign spi.done    = done_q;
  assign ptr_clr_n_c = rst_n & done_q;

  spi_tx_shifter u_tx (
    .sck    (spi.sck),
    .clr_n  (ptr_clr_n_c),
    .packet (packet_q),
    .sdo    (spi.sdo)
  );

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Self-checking bench for mcu_spi_slave: table vectors with hand-known bytes,
// randomized packets against a byte-level packet model, and handshake,
// freeze, partial-read, saturation and reset sequences.
module tb_mcu_spi_slave;

  typedef struct packed {
    logic [3:0][15:0] q1;   // [0]=w [1]=x [2]=y [3]=z
    logic [2:0][15:0] g1;   // [0]=x [1]=y [2]=z
    logic [3:0][15:0] q2;
    logic [2:0][15:0] g2;
    logic             q1v, g1v, q2v, g2v;
  } sens_t;

  // Expected bytes at positions 1,2,3,4,9,10,11,12,15,30 (leftmost first)
  typedef struct packed {
    sens_t       s;
    logic [79:0] exp;
  } vec_t;

  logic clk, rst_n;
  mcu_spi_if spi_bus ();

  sens_t cur;
  logic signed [15:0] quat1_w, quat1_x, quat1_y, quat1_z;
  logic signed [15:0] quat2_w, quat2_x, quat2_y, quat2_z;
  logic signed [15:0] gyro1_x, gyro1_y, gyro1_z, gyro2_x, gyro2_y, gyro2_z;
  logic quat1_valid, gyro1_valid, quat2_valid, gyro2_valid;

  assign quat1_w = cur.q1[0];  assign quat1_x = cur.q1[1];
  assign quat1_y = cur.q1[2];  assign quat1_z = cur.q1[3];
  assign gyro1_x = cur.g1[0];  assign gyro1_y = cur.g1[1];  assign gyro1_z = cur.g1[2];
  assign quat2_w = cur.q2[0];  assign quat2_x = cur.q2[1];
  assign quat2_y = cur.q2[2];  assign quat2_z = cur.q2[3];
  assign gyro2_x = cur.g2[0];  assign gyro2_y = cur.g2[1];  assign gyro2_z = cur.g2[2];
  assign quat1_valid = cur.q1v; assign gyro1_valid = cur.g1v;
  assign quat2_valid = cur.q2v; assign gyro2_valid = cur.g2v;

  mcu_spi_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_bus),
    .quat1_valid (quat1_valid),
    .gyro1_valid (gyro1_valid),
    .quat2_valid (quat2_valid),
    .gyro2_valid (gyro2_valid),
    .quat1_w     (quat1_w),
    .quat1_x     (quat1_x),
    .quat1_y     (quat1_y),
    .quat1_z     (quat1_z),
    .quat2_w     (quat2_w),
    .quat2_x     (quat2_x),
    .quat2_y     (quat2_y),
    .quat2_z     (quat2_z),
    .gyro1_x     (gyro1_x),
    .gyro1_y     (gyro1_y),
    .gyro1_z     (gyro1_z),
    .gyro2_x     (gyro2_x),
    .gyro2_y     (gyro2_y),
    .gyro2_z     (gyro2_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [7:0] exp_pkt [32];
  logic [7:0] rx [32];
  vec_t       tbl [3];
  int         pos_tbl [10] = '{1, 2, 3, 4, 9, 10, 11, 12, 15, 30};

  function automatic sens_t mk(
    logic [15:0] q1w, q1x, q1y, q1z, g1x, g1y, g1z,
    logic [15:0] q2w, q2x, q2y, q2z, g2x, g2y, g2z,
    logic [3:0]  v);  // {g2v, q2v, g1v, q1v}
    sens_t s;
    s.q1[0] = q1w; s.q1[1] = q1x; s.q1[2] = q1y; s.q1[3] = q1z;
    s.g1[0] = g1x; s.g1[1] = g1y; s.g1[2] = g1z;
    s.q2[0] = q2w; s.q2[1] = q2x; s.q2[2] = q2y; s.q2[3] = q2z;
    s.g2[0] = g2x; s.g2[1] = g2y; s.g2[2] = g2z;
    {s.g2v, s.q2v, s.g1v, s.q1v} = v;
    return s;
  endfunction

  function automatic sens_t rand_sens();
    return mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
  endfunction

  // Reference packet as a byte list built field by field
  function automatic void model(input sens_t s);
    logic [7:0]  q [$];
    logic [15:0] f [$];
    logic [7:0]  x;
    q.push_back(8'hAA);
    f = {s.q1[0], s.q1[1], s.q1[2], s.q1[3], s.g1[0], s.g1[1], s.g1[2]};
    foreach (f[i]) begin
      q.push_back(8'(f[i] / 256));
      q.push_back(8'(f[i] % 256));
    end
    q.push_back(8'(s.q1v) + 8'(s.g1v) * 8'd2);
    f = {s.q2[0], s.q2[1], s.q2[2], s.q2[3], s.g2[0], s.g2[1], s.g2[2]};
    foreach (f[i]) begin
      q.push_back(8'(f[i] / 256));
      q.push_back(8'(f[i] % 256));
    end
    q.push_back(8'(s.q2v) + 8'(s.g2v) * 8'd2);
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
    for (int i = 0; i < 32; i++) exp_pkt[i] = q[i];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_le(input string nm, input int act, input int lim);
    vec_cnt++;
    if (act > lim) begin
      miss_cnt++;
      $display("FAIL %s: got %0d cycles, limit %0d", nm, act, lim);
    end
  endtask

  task automatic read_bit(output logic v);
    #4;
    v = spi_bus.sdo;
    spi_bus.sdi = 1'($urandom);
    spi_bus.sck = 1'b1;
    #4;
    spi_bus.sck = 1'b0;
  endtask

  task automatic read_bytes(input int n);
    logic v;
    for (int b = 0; b < n; b++) begin
      for (int k = 7; k >= 0; k--) begin
        read_bit(v);
        rx[b][k] = v;
      end
    end
  endtask

  task automatic cmp_pkt(input string tag, input int n);
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), 32'(rx[i]), 32'(exp_pkt[i]));
  endtask

  // load pulse of 10 clk; checks done fall/rise latency and idle sdo
  task automatic do_load(input string tag);
    int fall, rise;
    @(negedge clk);
    spi_bus.load = 1'b1;
    fall = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (!spi_bus.done && fall == 99) fall = i;
    end
    @(negedge clk);
    spi_bus.load = 1'b0;
    rise = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (spi_bus.done) begin
        rise = i;
        break;
      end
    end
    check_le({tag, "_done_fall"}, fall, 3);
    check_le({tag, "_done_rise"}, rise, 4);
    check({tag, "_sdo_first_bit"}, 32'(spi_bus.sdo), 32'(exp_pkt[0][7]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;
    logic [79:0] e;
    int cyc;

    tbl[0].s   = mk(16'h4000, 16'h1000, 16'h2000, 16'h3000, 16'd100, 16'd200, 16'd300,
                    16'h5000, 16'h1100, 16'h2200, 16'h3300, 16'd400, 16'd500, 16'd600, 4'b1111);
    tbl[0].exp = 80'h40_00_10_00_00_64_00_C8_03_03;
    tbl[1].s   = mk(16'h4000, 16'h1000, 16'h2000, 16'h3000, 16'd100, 16'd200, 16'd300,
                    16'h5000, 16'h1100, 16'h2200, 16'h3300, 16'd400, 16'd500, 16'd600, 4'b0001);
    tbl[1].exp = 80'h40_00_10_00_00_64_00_C8_01_00;
    tbl[2].s   = mk(16'h8001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'hFF9C, 16'h0001, 16'h8000,
                    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'h00FF, 4'b1010);
    tbl[2].exp = 80'h80_01_FF_FF_FF_9C_00_01_02_02;

    rst_n = 1'b0;
    spi_bus.sck  = 1'b0;
    spi_bus.sdi  = 1'b0;
    spi_bus.load = 1'b0;
    cur = tbl[0].s;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(spi_bus.done), 32'd0);
    check("reset_sdo", 32'(spi_bus.sdo), 32'd0);

    // First capture after reset release
    rst_n = 1'b1;
    cyc = 99;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (spi_bus.done) begin cyc = i; break; end
    end
    check_le("reset_release_done", cyc, 2);
    model(cur);
    read_bytes(32);
    cmp_pkt("first", 32);

    // Table vectors
    for (int t = 0; t < 3; t++) begin
      cur = tbl[t].s;
      model(cur);
      do_load($sformatf("tbl%0d", t));
      read_bytes(32);
      cmp_pkt($sformatf("tbl%0d", t), 32);
      e = tbl[t].exp;
      for (int k = 0; k < 10; k++)
        check($sformatf("tbl%0d_known_byte%0d", t, pos_tbl[k]), 32'(rx[pos_tbl[k]]), 32'(e[79-8*k -: 8]));
    end

    // Extra sck edges past bit 255 repeat the last bit
    for (int i = 0; i < 8; i++) begin
      read_bit(v);
      check($sformatf("saturate_bit%0d", i), 32'(v), 32'(exp_pkt[31][0]));
    end

    // Freeze: inputs change while done is high
    cur = tbl[0].s;
    model(cur);
    do_load("freeze_a");
    cur.q1[0] = 16'h7FFF;
    read_bytes(32);
    cmp_pkt("freeze_held", 32);
    model(cur);
    do_load("freeze_b");
    read_bytes(32);
    cmp_pkt("freeze_updated", 32);
    check("freeze_updated_b1", 32'(rx[1]), 32'h7F);
    check("freeze_updated_b2", 32'(rx[2]), 32'hFF);

    // Partial read of 40 bits, then a fresh full packet
    cur = rand_sens();
    model(cur);
    do_load("partial_a");
    read_bytes(5);
    cmp_pkt("partial_head", 5);
    cur = rand_sens();
    model(cur);
    do_load("partial_b");
    read_bytes(32);
    cmp_pkt("partial_next", 32);
    check("partial_next_hdr", 32'(rx[0]), 32'hAA);

    // Randomized packets
    for (int r = 0; r < 12; r++) begin
      cur = rand_sens();
      model(cur);
      do_load($sformatf("rand%0d", r));
      read_bytes(32);
      cmp_pkt($sformatf("rand%0d", r), 32);
    end

    // Reset in the middle of a transfer
    cur = rand_sens();
    model(cur);
    do_load("rst_mid");
    read_bytes(2);
    for (int i = 0; i < 3; i++) read_bit(v);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_done", 32'(spi_bus.done), 32'd0);
    check("rst_mid_sdo", 32'(spi_bus.sdo), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_done", 32'(spi_bus.done), 32'd0);
    rst_n = 1'b1;
    cyc = 99;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (spi_bus.done) begin cyc = i; break; end
    end
    check_le("rst_mid_release_done", cyc, 2);
    read_bytes(32);
    cmp_pkt("rst_after", 32);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
